// File: rtl/reg_file_scoreboard_pkg.sv
// Shared definitions for the register-file scoreboard: register count,
// address type and default data width.
package reg_file_scoreboard_pkg;

  localparam int REG_ADDR_W = 2;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam int DATA_W_DEF = 8;
  localparam int PEND_W_DEF = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_file_scoreboard_pend_counter.sv
// Per-register pending-write counter: one saturating up/down counter.
// Increments on an issued write, decrements on a retiring write-back that
// finds it non-zero; both together leave it unchanged.
module pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              dec,
  output logic [PEND_W-1:0] count,
  output logic              zero,
  output logic              full,
  output logic              nonzero_next
);

  logic [PEND_W-1:0] count_next;
  logic              inc_eff;
  logic              dec_eff;

  assign zero    = (count == '0);
  assign full    = (count == '1);
  // A write-back against an empty counter is an error, not an underflow.
  assign inc_eff = inc & ~full;
  assign dec_eff = dec & ~zero;

  // Next-state count; the simultaneous inc/dec case cancels out.
  always_comb begin
    // NOTE: default assignment first so no path through the block leaves
    // count_next unassigned, which would otherwise infer a latch.
    count_next = count;
    unique case ({inc_eff, dec_eff})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  assign nonzero_next = (count_next != '0);

  // Counter state, discarded immediately on reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (reset) count <= '0;
    else       count <= count_next;
  end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file (4 x DATA_W, 2 combinational read ports, 1 write-back port)
// with a per-register pending-write scoreboard that stalls issue on RAW
// hazards and on a saturated destination counter.
// Optional feature: define WB_BYPASS_EN to forward same-cycle write-back data
// to the read ports and clear a retiring source hazard in that same cycle.
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int PEND_W = PEND_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [1:0]        issue_src1,
  input  logic [1:0]        issue_src2,
  input  logic              issue_src1_use,
  input  logic              issue_src2_use,
  input  logic              issue_wen,
  input  logic [1:0]        issue_dst,
  output logic              stall,
  output logic              issue_fire,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  input  logic              wb_valid,
  input  logic [1:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              pend_any,
  output logic              wb_err
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [PEND_W-1:0] p    [NUM_REGS];
  logic [NUM_REGS-1:0] p_zero;
  logic [NUM_REGS-1:0] p_full;
  logic [NUM_REGS-1:0] p_nz_next;
  logic [NUM_REGS-1:0] p_inc;
  logic [NUM_REGS-1:0] p_dec;

  reg_addr_t src1, src2, dst, wba;
  logic      src1_pend, src2_pend;
  logic      src_hz, dst_full;

  assign src1 = issue_src1;
  assign src2 = issue_src2;
  assign dst  = issue_dst;
  assign wba  = wb_addr;

  // One pending counter per architectural register.
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_pend
    assign p_inc[i] = issue_fire & issue_wen & (dst == reg_addr_t'(i));
    assign p_dec[i] = wb_valid & (wba == reg_addr_t'(i));

    pend_counter #(.PEND_W(PEND_W)) u_cnt (
      .clk          (clk),
      .reset        (reset),
      .inc          (p_inc[i]),
      .dec          (p_dec[i]),
      .count        (p[i]),
      .zero         (p_zero[i]),
      .full         (p_full[i]),
      .nonzero_next (p_nz_next[i])
    );
  end

`ifdef WB_BYPASS_EN
  logic byp1, byp2;
  assign byp1 = wb_valid & (wba == src1);
  assign byp2 = wb_valid & (wba == src2);

  // Read ports forward the write-back data for a same-cycle address match.
  assign rd_data1 = byp1 ? wb_data : regs[src1];
  assign rd_data2 = byp2 ? wb_data : regs[src2];

  // A source whose last outstanding write retires this cycle is not pending.
  assign src1_pend = (p[src1] != '0) & ~(byp1 & (p[src1] == PEND_W'(1)));
  assign src2_pend = (p[src2] != '0) & ~(byp2 & (p[src2] == PEND_W'(1)));
`else
  // Plain array reads; a write-back is visible from the following cycle.
  assign rd_data1 = regs[src1];
  assign rd_data2 = regs[src2];

  assign src1_pend = (p[src1] != '0);
  assign src2_pend = (p[src2] != '0);
`endif

  assign src_hz     = (issue_src1_use & src1_pend) | (issue_src2_use & src2_pend);
  assign dst_full   = issue_wen & p_full[dst];
  assign stall      = issue_valid & (src_hz | dst_full);
  assign issue_fire = issue_valid & ~stall;

  // Architectural register array; register 0 is an ordinary register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the array is small and architecturally defined as zero after
    // reset, so it is reset like any other flop rather than left as RAM.
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_valid) begin
      regs[wba] <= wb_data;
    end
  end

  // Registered summary flag and sticky write-back error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_any <= 1'b0;
      wb_err   <= 1'b0;
    end else begin
      pend_any <= |p_nz_next;
      if (wb_valid && p_zero[wba]) wb_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed self-checking bench for reg_file_scoreboard; expectations follow
// the build (WB_BYPASS_EN defined or not).
module tb_reg_file_scoreboard;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid, issue_src1_use, issue_src2_use, issue_wen;
  logic [1:0] issue_src1, issue_src2, issue_dst;
  logic       stall, issue_fire;
  logic [7:0] rd_data1, rd_data2;
  logic       wb_valid;
  logic [1:0] wb_addr;
  logic [7:0] wb_data;
  logic       pend_any, wb_err;

  int n_compared = 0;
  int n_mismatch = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard dut (
    .clk            (clk),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_src1     (issue_src1),
    .issue_src2     (issue_src2),
    .issue_src1_use (issue_src1_use),
    .issue_src2_use (issue_src2_use),
    .issue_wen      (issue_wen),
    .issue_dst      (issue_dst),
    .stall          (stall),
    .issue_fire     (issue_fire),
    .rd_data1       (rd_data1),
    .rd_data2       (rd_data2),
    .wb_valid       (wb_valid),
    .wb_addr        (wb_addr),
    .wb_data        (wb_data),
    .pend_any       (pend_any),
    .wb_err         (wb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_src1_use = 0; issue_src2_use = 0; issue_wen = 0;
    issue_src1 = 0; issue_src2 = 0; issue_dst = 0;
    wb_valid = 0; wb_addr = 0; wb_data = 0;
  endtask

  task automatic issue_write(input logic [1:0] d);
    issue_valid = 1; issue_wen = 1; issue_dst = d;
    issue_src1_use = 0; issue_src2_use = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    // Reset state, with an instruction presented during reset.
    issue_valid = 1; issue_src1_use = 1; issue_src1 = 2; issue_wen = 1; issue_dst = 1;
    #7;
    check("rst_stall", stall, 0);
    check("rst_fire", issue_fire, 1);
    check("rst_pend_any", pend_any, 0);
    check("rst_wb_err", wb_err, 0);
    check("rst_rd1", rd_data1, 0);
    idle();
    #5 reset = 0;
    step();

    // Test 1: issue a write to r2, write back A5, read it back.
    issue_write(2);
    #1 check("t1_fire", issue_fire, 1);
    step();
    idle();
    check("t1_pend_any_set", pend_any, 1);
    wb_valid = 1; wb_addr = 2; wb_data = 8'hA5;
    step();
    idle();
    issue_src1 = 2;
    #1;
    check("t1_rd1", rd_data1, 8'hA5);
    check("t1_wb_err", wb_err, 0);
    check("t1_pend_any_clr", pend_any, 0);

    // Test 2: RAW hazard on r1 until its write-back.
    step();
    issue_write(1);
    step();
    issue_valid = 1; issue_wen = 0; issue_src1_use = 1; issue_src1 = 1;
    #1 check("t2_stall_a", stall, 1);
    check("t2_fire_a", issue_fire, 0);
    step();
    check("t2_stall_b", stall, 1);
    wb_valid = 1; wb_addr = 1; wb_data = 8'h3C;
    #1;
`ifdef WB_BYPASS_EN
    check("t2_stall_wb", stall, 0);
    check("t2_rd1_byp", rd_data1, 8'h3C);
`else
    check("t2_stall_wb", stall, 1);
    check("t2_rd1_old", rd_data1, 0);
`endif
    step();
    wb_valid = 0;
    #1;
    check("t2_stall_after", stall, 0);
    check("t2_fire_after", issue_fire, 1);
    check("t2_rd1", rd_data1, 8'h3C);
    step();
    idle();

    // Test 3: three outstanding writes to r3 saturate its counter.
    for (int k = 0; k < 3; k++) begin
      issue_write(3);
      #1 check($sformatf("t3_fire%0d", k), issue_fire, 1);
      step();
    end
    #1 check("t3_stall_full", stall, 1);
    step();
    check("t3_stall_hold", stall, 1);
    wb_valid = 1; wb_addr = 3; wb_data = 8'h77;
    #1 check("t3_stall_wb_cycle", stall, 1);
    step();
    wb_valid = 0;
    #1 check("t3_fire4", issue_fire, 1);
    step();
    idle();
    // Drain the three outstanding r3 writes.
    for (int k = 0; k < 3; k++) begin
      wb_valid = 1; wb_addr = 3; wb_data = 8'h70 + 8'(k);
      step();
    end
    idle();
    #1 check("t3_drained", pend_any, 0);
    check("t3_no_err", wb_err, 0);

    // Test 4: issue to r0 and retire r0 in the same cycle keeps p[0]=1.
    issue_write(0);
    step();
    issue_write(0);
    wb_valid = 1; wb_addr = 0; wb_data = 8'h11;
    #1 check("t4_fire", issue_fire, 1);
    step();
    idle();
    #1 check("t4_pend_any", pend_any, 1);
    issue_valid = 1; issue_src1_use = 1; issue_src1 = 0;
    #1 check("t4_stall_r0", stall, 1);
    step();
    wb_valid = 1; wb_addr = 0; wb_data = 8'h22;
    step();
    wb_valid = 0;
    #1 check("t4_stall_clear", stall, 0);
    check("t4_pend_any_clr", pend_any, 0);
    check("t4_rd1", rd_data1, 8'h22);
    check("t4_no_err", wb_err, 0);
    idle();

    // Test 5: write-back to r2 with nothing pending sets sticky wb_err.
    wb_valid = 1; wb_addr = 2; wb_data = 8'h5A;
    step();
    idle();
    issue_src2 = 2;
    #1 check("t5_wb_err", wb_err, 1);
    check("t5_rd2", rd_data2, 8'h5A);
    check("t5_pend_any", pend_any, 0);
    step(); step();
    check("t5_wb_err_sticky", wb_err, 1);

    // Test 6: async reset with two writes outstanding on r1.
    issue_write(1);
    step();
    step();
    issue_wen = 0; issue_src1_use = 1; issue_src1 = 1; issue_src2 = 2;
    #1 check("t6_stall_pre", stall, 1);
    check("t6_pend_any_pre", pend_any, 1);
    #2 reset = 1;
    #1;
    check("t6_stall_rst", stall, 0);
    check("t6_fire_rst", issue_fire, 1);
    check("t6_pend_any_rst", pend_any, 0);
    check("t6_wb_err_rst", wb_err, 0);
    check("t6_rd1_rst", rd_data1, 0);
    check("t6_rd2_rst", rd_data2, 0);
    // A write-back while reset is held is dropped.
    idle();
    wb_valid = 1; wb_addr = 0; wb_data = 8'hFF;
    step();
    idle();
    reset = 0;
    issue_src2 = 0;
    #1 check("t6_wb_dropped", rd_data2, 0);
    check("t6_wb_err_after", wb_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule
